// File: rtl/fpu_share_pkg.sv
// Shared constants and types for the FPU sharing controller.
// Flag bit positions, FPU opcodes and the in-flight tag record.
package fpu_share_pkg;

    localparam int FLG_INF  = 0;
    localparam int FLG_IND  = 1;
    localparam int FLG_QNAN = 2;
    localparam int FLG_SNAN = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    // Wide enough for any requester id up to NREQ=8.
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational rotate-priority picker: first set request at or
// above ptr, wrapping modulo NREQ; one-hot grant plus encoded id.
module fpu_rr_pick
    import fpu_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_share_ctrl.sv
// Round-robin sharing of one pipelined FPU among NREQ requesters.
// Define FPU_SHARE_STICKY_EN to add per-requester sticky flags.
module fpu_share_ctrl
    import fpu_share_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int FPU_LAT = 4,
    parameter  int OP_W    = 3,
    parameter  int ID_W    = 2,
    // Sized so the peak count of FPU_LAT+2 always fits.
    localparam int CNT_W   = $clog2(FPU_LAT + 3)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef FPU_SHARE_STICKY_EN
    input  logic [NREQ-1:0]      sticky_clr,
    output logic [NREQ*4-1:0]    sticky_flags,
`endif
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_opa,
    input  logic [NREQ*32-1:0]   req_opb,
    input  logic [NREQ*OP_W-1:0] req_op,
    output logic                 fpu_start,
    output logic [31:0]          fpu_opa,
    output logic [31:0]          fpu_opb,
    output logic [OP_W-1:0]      fpu_op,
    input  logic [31:0]          fpu_result,
    input  logic [3:0]           fpu_flags,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_data,
    output logic [3:0]           resp_flags,
    output logic                 busy,
    output logic [CNT_W-1:0]     inflight
);

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] gid;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] iss_id;
    logic            fire;
    logic            resp_any;
    tag_t            pipe [FPU_LAT];
    tag_t            last;

    fpu_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (gid)
    );

    assign req_ready = grant;
    assign fire      = |grant;
    assign resp_any  = |resp_valid;
    // The final tag stage lines up with fpu_result.
    assign last      = pipe[FPU_LAT-1];
    assign busy      = (inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            iss_id     <= '0;
            fpu_start  <= 1'b0;
            fpu_opa    <= '0;
            fpu_opb    <= '0;
            fpu_op     <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
            inflight   <= '0;
            for (int k = 0; k < FPU_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            fpu_start <= fire;
            if (fire) begin
                rr_ptr  <= (gid == ID_W'(NREQ - 1)) ? '0 : gid + ID_W'(1);
                iss_id  <= gid;
                fpu_opa <= req_opa[int'(gid)*32 +: 32];
                fpu_opb <= req_opb[int'(gid)*32 +: 32];
                fpu_op  <= req_op[int'(gid)*OP_W +: OP_W];
            end

            pipe[0] <= '{valid: fpu_start, id: TAG_ID_W'(iss_id)};
            for (int k = 1; k < FPU_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end

            resp_valid <= last.valid ? NREQ'(1) << last.id : '0;
            if (last.valid) begin
                resp_data  <= fpu_result;
                resp_flags <= fpu_flags;
            end

            if (fire && !resp_any) begin
                inflight <= inflight + CNT_W'(1);
            end else if (!fire && resp_any) begin
                inflight <= inflight - CNT_W'(1);
            end
        end
    end

`ifdef FPU_SHARE_STICKY_EN
    // Clear first, then OR in the new flags, so a same-cycle set survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (sticky_clr[i] || resp_valid[i]) begin
                    sticky_flags[i*4 +: 4] <=
                        (sticky_clr[i] ? 4'b0 : sticky_flags[i*4 +: 4]) |
                        (resp_valid[i] ? resp_flags : 4'b0);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Directed self-checking bench for fpu_share_ctrl with a stand-in
// fixed-latency FPU; sticky checks build with FPU_SHARE_STICKY_EN.
module tb_fpu_share_ctrl;
    import fpu_share_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int OP_W = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_opa = '0;
    logic [NREQ*32-1:0]   req_opb = '0;
    logic [NREQ*OP_W-1:0] req_op = '0;
    logic                 fpu_start;
    logic [31:0]          fpu_opa, fpu_opb;
    logic [OP_W-1:0]      fpu_op;
    logic [31:0]          fpu_result;
    logic [3:0]           fpu_flags;
    logic [NREQ-1:0]      resp_valid;
    logic [31:0]          resp_data;
    logic [3:0]           resp_flags;
    logic                 busy;
    logic [2:0]           inflight;
`ifdef FPU_SHARE_STICKY_EN
    logic [NREQ-1:0]      sticky_clr = '0;
    logic [NREQ*4-1:0]    sticky_flags;
`endif

    int total = 0;
    int bad   = 0;

    fpu_share_ctrl #(
        .NREQ(NREQ), .FPU_LAT(LAT), .OP_W(OP_W), .ID_W(2)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef FPU_SHARE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op),
        .fpu_start(fpu_start), .fpu_opa(fpu_opa),
        .fpu_opb(fpu_opb), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_flags(resp_flags), .busy(busy), .inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fres(logic [2:0] op,
                                         logic [31:0] a, logic [31:0] b);
        if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000)
            return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {29'b0, op};
    endfunction

    function automatic logic [3:0] fflg(logic [31:0] a, logic [31:0] b);
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return 4'b0011;
        if (a[30:23] == 8'hFF) return 4'b0001;
        if (b[30:23] == 8'hFF) return 4'b0100;
        return 4'b0000;
    endfunction

    logic [31:0] pr [LAT];
    logic [3:0]  pf [LAT];
    assign fpu_result = pr[LAT-1];
    assign fpu_flags  = pf[LAT-1];

    // Idle slots carry junk so a response built from them is visible.
    always @(posedge clk) begin
        pr[0] <= fpu_start ? fres(fpu_op, fpu_opa, fpu_opb) : 32'hDEAD_BEEF;
        pf[0] <= fpu_start ? fflg(fpu_opa, fpu_opb) : 4'hF;
        for (int k = 1; k < LAT; k++) begin
            pr[k] <= pr[k-1];
            pf[k] <= pf[k-1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
`ifdef FPU_SHARE_STICKY_EN
        sticky_clr = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        req_opa[i*32 +: 32]     = a;
        req_opb[i*32 +: 32]     = b;
        req_op[i*OP_W +: OP_W]  = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (req_ready !== 4'b0) begin
            bad++; $display("FAIL rst_ready got %b want 0000", req_ready);
        end
        total++;
        if (fpu_start !== 1'b0 || fpu_opa !== 32'h0 || fpu_op !== 3'h0) begin
            bad++; $display("FAIL rst_fpu got %b %h %h want 0 0 0",
                            fpu_start, fpu_opa, fpu_op);
        end
        total++;
        if (resp_valid !== 4'b0 || resp_data !== 32'h0 || resp_flags !== 4'h0) begin
            bad++; $display("FAIL rst_resp got %b %h %b want 0 0 0",
                            resp_valid, resp_data, resp_flags);
        end
        total++;
        if (busy !== 1'b0 || inflight !== 3'd0) begin
            bad++; $display("FAIL rst_cnt got %b %0d want 0 0", busy, inflight);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_ready got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        total++;
        if (fpu_start !== 1'b1 || fpu_opa !== 32'h3F80_0000 ||
            fpu_opb !== 32'h4000_0000 || fpu_op !== OP_ADD) begin
            bad++; $display("FAIL single_issue got %b %h %h %h want 1 3f800000 40000000 0",
                            fpu_start, fpu_opa, fpu_opb, fpu_op);
        end
        total++;
        if (inflight !== 3'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_inflight1 got %0d %b want 1 1", inflight, busy);
        end
        tick();
        total++;
        if (fpu_start !== 1'b0 || fpu_opa !== 32'h3F80_0000) begin
            bad++; $display("FAIL single_hold got %b %h want 0 3f800000",
                            fpu_start, fpu_opa);
        end
        repeat (3) tick();
        total++;
        if (resp_valid !== 4'b0000) begin
            bad++; $display("FAIL single_early got %b want 0000", resp_valid);
        end
        tick();
        total++;
        if (resp_valid !== 4'b0001 || resp_data !== 32'h4040_0000) begin
            bad++; $display("FAIL single_resp got %b %h want 0001 40400000",
                            resp_valid, resp_data);
        end
        tick();
        total++;
        if (resp_valid !== 4'b0 || resp_data !== 32'h4040_0000 ||
            inflight !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_after got %b %h %0d %b want 0000 40400000 0 0",
                            resp_valid, resp_data, inflight, busy);
        end
    endtask

    task automatic test_contention();
        logic [31:0] ea [NREQ];
        logic [31:0] eb [NREQ];
        logic [2:0]  eo [NREQ];
        logic [3:0]  eg;
        int          r, ei, peak;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ea[i] = 32'h4100_0000 + 32'(i);
            eb[i] = 32'h3F00_0000 + 32'(i << 4);
            eo[i] = 3'(i);
            set_req(i, ea[i], eb[i], eo[i]);
        end
        peak = 0;
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
            total++;
            if (req_ready !== eg) begin
                bad++; $display("FAIL cont_grant c=%0d got %b want %b", c, req_ready, eg);
            end
            if (c >= 6 && c < 14) begin
                r  = (c - 6) % 4;
                eg = 4'(1 << r);
                total++;
                if (resp_valid !== eg || resp_data !== fres(eo[r], ea[r], eb[r])) begin
                    bad++; $display("FAIL cont_resp c=%0d got %b %h want %b %h",
                                    c, resp_valid, resp_data, eg,
                                    fres(eo[r], ea[r], eb[r]));
                end
            end else begin
                total++;
                if (resp_valid !== 4'b0) begin
                    bad++; $display("FAIL cont_idle c=%0d got %b want 0000", c, resp_valid);
                end
            end
            ei = ((c < 8) ? c : 8) - ((c < 6) ? 0 : ((c - 6 > 8) ? 8 : c - 6));
            total++;
            if (inflight !== 3'(ei)) begin
                bad++; $display("FAIL cont_inflight c=%0d got %0d want %0d", c, inflight, ei);
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            tick();
        end
        total++;
        if (peak != 6) begin
            bad++; $display("FAIL cont_peak got %0d want 6", peak);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL wrap_setup got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0101;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL wrap_to0 got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0101;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL wrap_skip got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic test_flags();
        do_reset();
        set_req(2, 32'h7F80_0000, 32'h7FC0_0000, OP_ADD);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        repeat (5) tick();
        total++;
        if (resp_valid !== 4'b0100 || resp_flags !== 4'b0011 ||
            resp_data !== fres(OP_ADD, 32'h7F80_0000, 32'h7FC0_0000)) begin
            bad++; $display("FAIL flags_resp got %b %b %h want 0100 0011 %h",
                            resp_valid, resp_flags, resp_data,
                            fres(OP_ADD, 32'h7F80_0000, 32'h7FC0_0000));
        end
        tick();
        total++;
        if (resp_valid !== 4'b0 || resp_flags !== 4'b0011) begin
            bad++; $display("FAIL flags_after got %b %b want 0000 0011",
                            resp_valid, resp_flags);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        set_req(0, 32'h1111_1111, 32'h2222_2222, OP_SUB);
        set_req(1, 32'h3333_3333, 32'h4444_4444, OP_MUL);
        set_req(2, 32'h5555_5555, 32'h6666_6666, OP_DIV);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (fpu_start !== 1'b0 || fpu_opa !== 32'h0 || fpu_opb !== 32'h0 ||
            fpu_op !== 3'h0) begin
            bad++; $display("FAIL mid_fpu got %b %h %h %h want 0 0 0 0",
                            fpu_start, fpu_opa, fpu_opb, fpu_op);
        end
        total++;
        if (resp_valid !== 4'b0 || resp_data !== 32'h0 || resp_flags !== 4'h0 ||
            busy !== 1'b0 || inflight !== 3'd0) begin
            bad++; $display("FAIL mid_resp got %b %h %b %b %0d want 0 0 0 0 0",
                            resp_valid, resp_data, resp_flags, busy, inflight);
        end
        tick();
        rst   = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (resp_valid !== 4'b0) stray++;
        end
        total++;
        if (stray != 0 || inflight !== 3'd0) begin
            bad++; $display("FAIL mid_stray got %0d %0d want 0 0", stray, inflight);
        end
    endtask

`ifdef FPU_SHARE_STICKY_EN
    task automatic test_sticky();
        do_reset();
        set_req(1, 32'h7F80_0000, 32'h3F80_0000, OP_MUL);
        req_valid = 4'b0010;
        tick();
        set_req(1, 32'h3F80_0000, 32'h7F80_0000, OP_MUL);
        tick();
        req_valid = 4'b0000;
        repeat (5) tick();
        total++;
        if (sticky_flags !== 16'h0010) begin
            bad++; $display("FAIL sticky_first got %h want 0010", sticky_flags);
        end
        tick();
        total++;
        if (sticky_flags !== 16'h0050) begin
            bad++; $display("FAIL sticky_both got %h want 0050", sticky_flags);
        end
        sticky_clr = 4'b0010;
        tick();
        sticky_clr = 4'b0000;
        total++;
        if (sticky_flags !== 16'h0000) begin
            bad++; $display("FAIL sticky_clr got %h want 0000", sticky_flags);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_flags();
        test_reset_mid();
`ifdef FPU_SHARE_STICKY_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
